// File: rtl/ifetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: constants, state and PC-select encodings, IF/ID payload.
package ifetch_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = 32'h0000_0004;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_LOAD = 2'd2
  } pc_sel_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc: '0, valid: 1'b0};

  // Instruction addresses must be word aligned.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_stage_pc_unit.sv
// PC register with next-PC mux: hold, sequential +4 (mod 2^32), or redirect load.
module ifetch_stage_pc_unit
  import ifetch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  pc_sel_e         sel_i,
  input  logic [XLEN-1:0] target_i,
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  // Next-PC selection; the +4 wraps naturally at 32 bits.
  always_comb begin
    pc_d = pc_q;
    case (sel_i)
      PC_INC:  pc_d = XLEN'(pc_q + PC_STEP);
      PC_LOAD: pc_d = target_i;
      default: pc_d = pc_q;
    endcase
  end

  // PC register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: fetch FSM, IF/ID pipeline register and sticky halt around the PC unit.
module ifetch_stage
  import ifetch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr_out_if,
  input  logic [XLEN-1:0] imem_data_in_if,
  input  logic            stall_in_if,
  input  logic            redirect_in_if,
  input  logic [XLEN-1:0] redirect_pc_in_if,
  input  logic            halt_req_in_if,
  output logic [XLEN-1:0] instr_out_if,
  output logic [XLEN-1:0] pc_out_if,
  output logic            valid_out_if,
  output logic            halt_out_if
);

  fetch_state_e    state_q;
  ifid_t           ifid_q;
  logic            halt_q;
  logic [XLEN-1:0] pc;
  pc_sel_e         pc_sel;
  logic            enter_halt_c;

  // A halt request or a misaligned redirect target both stop fetch for good.
  assign enter_halt_c = halt_req_in_if
                      | (redirect_in_if & is_misaligned(redirect_pc_in_if));

  // PC update only in RUN; redirect beats stall, halt beats everything.
  always_comb begin
    pc_sel = PC_HOLD;
    if (state_q == RUN) begin
      if (enter_halt_c) begin
        pc_sel = PC_HOLD;
      end else if (redirect_in_if) begin
        pc_sel = PC_LOAD;
      end else if (!stall_in_if) begin
        pc_sel = PC_INC;
      end
    end
  end

  ifetch_stage_pc_unit u_pc_unit (
    .clk      (clk),
    .rst      (rst),
    .sel_i    (pc_sel),
    .target_i (redirect_pc_in_if),
    .pc_o     (pc)
  );

  // Fetch FSM with the IF/ID register and sticky halt flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= BOOT;
      ifid_q  <= IFID_BUBBLE;
      halt_q  <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q <= RUN;
        end
        RUN: begin
          if (enter_halt_c) begin
            state_q <= HALTED;
            halt_q  <= 1'b1;
            ifid_q  <= IFID_BUBBLE;
          end else if (redirect_in_if) begin
            ifid_q <= IFID_BUBBLE;
          end else if (!stall_in_if) begin
            ifid_q <= '{instr: imem_data_in_if, pc: pc, valid: 1'b1};
          end
        end
        HALTED: begin
          state_q <= HALTED;
        end
        default: begin
          state_q <= BOOT;
          ifid_q  <= IFID_BUBBLE;
        end
      endcase
    end
  end

  assign imem_addr_out_if = pc;
  assign instr_out_if     = ifid_q.instr;
  assign pc_out_if        = ifid_q.pc;
  assign valid_out_if     = ifid_q.valid;
  assign halt_out_if      = halt_q;

endmodule

// File: tb/tb_ifetch_stage.sv
// Scoreboard bench for ifetch_stage: a behavioural model pushes expected outputs per cycle, checked after each edge.
module tb_ifetch_stage;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        valid_o;
  logic        halt_o;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        halt;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  int          m_state;   // 0 boot, 1 run, 2 halted
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  logic        m_valid;
  logic        m_halt;

  ifetch_stage dut (
    .clk               (clk),
    .rst               (rst),
    .imem_addr_out_if  (imem_addr),
    .imem_data_in_if   (imem_data),
    .stall_in_if       (stall),
    .redirect_in_if    (redirect),
    .redirect_pc_in_if (redirect_pc),
    .halt_req_in_if    (halt_req),
    .instr_out_if      (instr_o),
    .pc_out_if         (pc_o),
    .valid_out_if      (valid_o),
    .halt_out_if       (halt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational instruction memory: word = address | A000_0000.
  assign imem_data = imem_addr | 32'hA000_0000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_pc    = 32'h0;
    m_instr = 32'h13;
    m_ipc   = 32'h0;
    m_valid = 1'b0;
    m_halt  = 1'b0;
  endtask

  // Drive one cycle of stimulus, advance the model, push the expectation, then compare after the edge.
  task automatic step(input logic r, input logic st, input logic rd,
                      input logic [31:0] tg, input logic hr);
    exp_t e;
    exp_t g;
    @(negedge clk);
    rst = r; stall = st; redirect = rd; redirect_pc = tg; halt_req = hr;
    if (!r) begin
      model_reset();
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if (hr || (rd && (tg[1:0] != 2'b00))) begin
        m_state = 2; m_halt = 1'b1;
        m_instr = 32'h13; m_ipc = 32'h0; m_valid = 1'b0;
      end else if (rd) begin
        m_pc = tg;
        m_instr = 32'h13; m_ipc = 32'h0; m_valid = 1'b0;
      end else if (!st) begin
        m_instr = m_pc | 32'hA000_0000;
        m_ipc   = m_pc;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
      end
    end
    e = '{addr: m_pc, instr: m_instr, pc: m_ipc, valid: m_valid, halt: m_halt};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      g = exp_q.pop_front();
      chk("addr",  imem_addr, g.addr);
      chk("instr", instr_o,   g.instr);
      chk("pc",    pc_o,      g.pc);
      chk("valid", {31'd0, valid_o}, {31'd0, g.valid});
      chk("halt",  {31'd0, halt_o},  {31'd0, g.halt});
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; halt_req = 1'b0;
    model_reset();

    // Reset state
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_instr", instr_o,   32'h13);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);

    // BOOT cycle, then fetch from 0, 4
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("boot_valid", {31'd0, valid_o}, 32'd0);
    chk("boot_addr",  imem_addr, 32'h0);
    run(1);
    chk("first_instr", instr_o, 32'hA000_0000);
    chk("first_pc",    pc_o,    32'h0);
    chk("first_addr",  imem_addr, 32'h4);
    run(1);
    chk("addr8", imem_addr, 32'h8);

    // Stall for 3 cycles at PC=8
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("stall_addr", imem_addr, 32'h8);
      chk("stall_pc",   pc_o,      32'h4);
    end
    run(1);
    chk("resume_pc", pc_o, 32'h8);

    // Redirect overrides stall
    step(1'b1, 1'b1, 1'b1, 32'h100, 1'b0);
    chk("redir_addr",  imem_addr, 32'h100);
    chk("redir_valid", {31'd0, valid_o}, 32'd0);
    chk("redir_instr", instr_o, 32'h13);
    run(1);
    chk("redir_tgt_pc", pc_o, 32'h100);
    run(2);

    // Misaligned redirect halts
    step(1'b1, 1'b0, 1'b1, 32'h102, 1'b0);
    chk("mis_halt", {31'd0, halt_o}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, i[0], i[1], 32'h200, 1'b0);
      chk("halted_valid", {31'd0, valid_o}, 32'd0);
      chk("halted_addr",  imem_addr, 32'h10C);
    end

    // Reset out of HALTED, then halt request pulse, then reset
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("rst_halt_clr", {31'd0, halt_o}, 32'd0);
    run(4);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("hreq_halt", {31'd0, halt_o}, 32'd1);
    run(2);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("hreq_rst_addr", imem_addr, 32'h0);
    run(2);
    chk("refetch_instr", instr_o, 32'hA000_0000);

    // Reset during redirect/stall wins
    run(2);
    step(1'b0, 1'b1, 1'b1, 32'h400, 1'b0);
    chk("rst_vs_redir", imem_addr, 32'h0);
    run(1);

    // PC wrap at 32'hFFFF_FFFC
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    run(1);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pc",   pc_o, 32'hFFFF_FFFC);
    chk("wrap_halt", {31'd0, halt_o}, 32'd0);
    run(1);
    chk("wrap_pc0", pc_o, 32'h0);

    // Random mix of stalls, aligned redirects, rare halt/reset
    for (int i = 0; i < 60; i++) begin
      logic        r_rst;
      logic        r_st;
      logic        r_rd;
      logic        r_hr;
      logic [31:0] r_tg;
      r_rst = ($urandom_range(0, 29) != 0);
      r_st  = ($urandom_range(0, 3) == 0);
      r_rd  = ($urandom_range(0, 5) == 0);
      r_hr  = ($urandom_range(0, 39) == 0);
      r_tg  = {$urandom_range(0, 255), 2'b00} & 32'h0000_03FC;
      step(r_rst, r_st, r_rd, r_tg, r_hr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
